// File: rtl/tcp_tx_flow_sched.sv
// Round-robin per-flow TX scheduler holding DATA/RTX pending bits per flow.
// Defining TX_FLOW_SCHED_PERF_CNT_EN adds saturating issued/stall counters.
module tcp_tx_flow_sched #(
   parameter int FLOWID_W   = 8,
   parameter int SCAN_START = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                src0_cmd_val,
   input  logic [FLOWID_W-1:0] src0_cmd_flowid,
   input  logic [1:0]          src0_cmd_op,
   output logic                src0_cmd_rdy,
   input  logic                src1_cmd_val,
   input  logic [FLOWID_W-1:0] src1_cmd_flowid,
   input  logic [1:0]          src1_cmd_op,
   output logic                src1_cmd_rdy,
   input  logic                new_flow_val,
   input  logic [FLOWID_W-1:0] new_flow_flowid,
   output logic                sched_tx_req_val,
   output logic [FLOWID_W-1:0] sched_tx_req_flowid,
   output logic                sched_tx_req_data,
   output logic                sched_tx_req_rtx,
   input  logic                tx_sched_req_rdy
`ifdef TX_FLOW_SCHED_PERF_CNT_EN
   ,
   output logic [31:0]         issued_cnt,
   output logic [31:0]         stall_cnt
`endif
);

   localparam int NFLOW = 1 << FLOWID_W;
   localparam logic [1:0] OP_NOP      = 2'b00;
   localparam logic [1:0] OP_SET_DATA = 2'b01;
   localparam logic [1:0] OP_SET_RTX  = 2'b10;
   localparam logic [1:0] OP_CLEAR    = 2'b11;
   localparam logic [NFLOW-1:0]    FLOW_ONE = NFLOW'(1);
   localparam logic [FLOWID_W-1:0] FID_ONE  = FLOWID_W'(1);

   typedef enum logic [0:0] {ST_SCAN = 1'b0, ST_OFFER = 1'b1} state_t;

   state_t              state_r, state_nxt_s;
   logic [FLOWID_W-1:0] ptr_r, ptr_nxt_s;
   logic [NFLOW-1:0]    data_r, rtx_r, data_nxt_s, rtx_nxt_s;
   logic [NFLOW-1:0]    hs_sel_s, cmd_sel_s, new_sel_s, clr_sel_s;
   logic                cmd_acc_s, hs_s, pend_any_s;
   logic [FLOWID_W-1:0] cmd_flowid_s;
   logic [1:0]          cmd_op_s;
   logic                val_nxt_s, data_snap_nxt_s, rtx_snap_nxt_s;
   logic [FLOWID_W-1:0] flowid_nxt_s;

   assign src0_cmd_rdy = rst;
   assign src1_cmd_rdy = rst & ~src0_cmd_val;

   // Fixed-priority pick of the single command accepted this cycle
   always_comb begin
      cmd_acc_s    = 1'b0;
      cmd_flowid_s = '0;
      cmd_op_s     = OP_NOP;
      if (src0_cmd_val) begin
         cmd_acc_s    = 1'b1;
         cmd_flowid_s = src0_cmd_flowid;
         cmd_op_s     = src0_cmd_op;
      end else if (src1_cmd_val) begin
         cmd_acc_s    = 1'b1;
         cmd_flowid_s = src1_cmd_flowid;
         cmd_op_s     = src1_cmd_op;
      end else begin
         cmd_acc_s    = 1'b0;
      end
   end

   // Handshake clear first, then command sets, then clears; new_flow overrides all
   assign hs_s       = (state_r == ST_OFFER) & sched_tx_req_val & tx_sched_req_rdy;
   assign hs_sel_s   = hs_s ? (FLOW_ONE << sched_tx_req_flowid) : '0;
   assign cmd_sel_s  = cmd_acc_s ? (FLOW_ONE << cmd_flowid_s) : '0;
   assign new_sel_s  = new_flow_val ? (FLOW_ONE << new_flow_flowid) : '0;
   assign clr_sel_s  = new_sel_s | ((cmd_op_s == OP_CLEAR) ? cmd_sel_s : '0);
   assign data_nxt_s = ((data_r & ~(sched_tx_req_data ? hs_sel_s : '0))
                        | ((cmd_op_s == OP_SET_DATA) ? cmd_sel_s : '0)) & ~clr_sel_s;
   assign rtx_nxt_s  = ((rtx_r & ~(sched_tx_req_rtx ? hs_sel_s : '0))
                        | ((cmd_op_s == OP_SET_RTX) ? cmd_sel_s : '0)) & ~clr_sel_s;
   assign pend_any_s = data_r[ptr_r] | rtx_r[ptr_r];

   // Scan/offer next-state and next registered request fields
   always_comb begin
      state_nxt_s     = state_r;
      ptr_nxt_s       = ptr_r;
      val_nxt_s       = sched_tx_req_val;
      flowid_nxt_s    = sched_tx_req_flowid;
      data_snap_nxt_s = sched_tx_req_data;
      rtx_snap_nxt_s  = sched_tx_req_rtx;
      case (state_r)
         ST_SCAN: begin
            if (pend_any_s) begin
               state_nxt_s     = ST_OFFER;
               val_nxt_s       = 1'b1;
               flowid_nxt_s    = ptr_r;
               data_snap_nxt_s = data_r[ptr_r];
               rtx_snap_nxt_s  = rtx_r[ptr_r];
            end else begin
               val_nxt_s       = 1'b0;
               ptr_nxt_s       = ptr_r + FID_ONE;
            end
         end
         ST_OFFER: begin
            if (tx_sched_req_rdy) begin
               state_nxt_s = ST_SCAN;
               val_nxt_s   = 1'b0;
               ptr_nxt_s   = sched_tx_req_flowid + FID_ONE;
            end else begin
               state_nxt_s = ST_OFFER;
            end
         end
         default: begin
            state_nxt_s = ST_SCAN;
            val_nxt_s   = 1'b0;
         end
      endcase
   end

   // State, scan pointer, pending bits and registered request outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r             <= ST_SCAN;
         ptr_r               <= FLOWID_W'(SCAN_START);
         data_r              <= '0;
         rtx_r               <= '0;
         sched_tx_req_val    <= 1'b0;
         sched_tx_req_flowid <= '0;
         sched_tx_req_data   <= 1'b0;
         sched_tx_req_rtx    <= 1'b0;
      end else begin
         state_r             <= state_nxt_s;
         ptr_r               <= ptr_nxt_s;
         data_r              <= data_nxt_s;
         rtx_r               <= rtx_nxt_s;
         sched_tx_req_val    <= val_nxt_s;
         sched_tx_req_flowid <= flowid_nxt_s;
         sched_tx_req_data   <= data_snap_nxt_s;
         sched_tx_req_rtx    <= rtx_snap_nxt_s;
      end
   end

`ifdef TX_FLOW_SCHED_PERF_CNT_EN
   // Saturating counters of issued requests and back-pressured offer cycles
   always_ff @(posedge clk) begin
      if (!rst) begin
         issued_cnt <= 32'd0;
         stall_cnt  <= 32'd0;
      end else begin
         if (hs_s && (issued_cnt != 32'hFFFF_FFFF)) begin
            issued_cnt <= issued_cnt + 32'd1;
         end else begin
            issued_cnt <= issued_cnt;
         end
         if (sched_tx_req_val && !tx_sched_req_rdy && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end else begin
            stall_cnt <= stall_cnt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_tcp_tx_flow_sched.sv
// Directed bench for tcp_tx_flow_sched with FLOWID_W=3; handshakes are logged and checked in order.
module tb_tcp_tx_flow_sched;

   localparam logic [1:0] OP_NOP      = 2'b00;
   localparam logic [1:0] OP_SET_DATA = 2'b01;
   localparam logic [1:0] OP_SET_RTX  = 2'b10;
   localparam logic [1:0] OP_CLEAR    = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       src0_cmd_val = 1'b0;
   logic [2:0] src0_cmd_flowid = 3'd0;
   logic [1:0] src0_cmd_op = 2'b00;
   logic       src0_cmd_rdy;
   logic       src1_cmd_val = 1'b0;
   logic [2:0] src1_cmd_flowid = 3'd0;
   logic [1:0] src1_cmd_op = 2'b00;
   logic       src1_cmd_rdy;
   logic       new_flow_val = 1'b0;
   logic [2:0] new_flow_flowid = 3'd0;
   logic       sched_tx_req_val;
   logic [2:0] sched_tx_req_flowid;
   logic       sched_tx_req_data;
   logic       sched_tx_req_rtx;
   logic       tx_sched_req_rdy = 1'b0;
`ifdef TX_FLOW_SCHED_PERF_CNT_EN
   logic [31:0] issued_cnt;
   logic [31:0] stall_cnt;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          gap_err = 0;
   logic        prev_hs = 1'b0;
   logic [31:0] iss_q[$];
   int          iss_cyc[$];

   tcp_tx_flow_sched #(.FLOWID_W(3), .SCAN_START(0)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .src0_cmd_val        (src0_cmd_val),
      .src0_cmd_flowid     (src0_cmd_flowid),
      .src0_cmd_op         (src0_cmd_op),
      .src0_cmd_rdy        (src0_cmd_rdy),
      .src1_cmd_val        (src1_cmd_val),
      .src1_cmd_flowid     (src1_cmd_flowid),
      .src1_cmd_op         (src1_cmd_op),
      .src1_cmd_rdy        (src1_cmd_rdy),
      .new_flow_val        (new_flow_val),
      .new_flow_flowid     (new_flow_flowid),
      .sched_tx_req_val    (sched_tx_req_val),
      .sched_tx_req_flowid (sched_tx_req_flowid),
      .sched_tx_req_data   (sched_tx_req_data),
      .sched_tx_req_rtx    (sched_tx_req_rtx),
      .tx_sched_req_rdy    (tx_sched_req_rdy)
`ifdef TX_FLOW_SCHED_PERF_CNT_EN
      ,
      .issued_cnt          (issued_cnt),
      .stall_cnt           (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Log every handshake and flag a request that follows a handshake with no idle cycle
   always @(posedge clk) begin
      cyc <= cyc + 1;
      prev_hs <= rst & sched_tx_req_val & tx_sched_req_rdy;
      if (rst && sched_tx_req_val && tx_sched_req_rdy) begin
         iss_q.push_back({27'd0, sched_tx_req_flowid, sched_tx_req_data, sched_tx_req_rtx});
         iss_cyc.push_back(cyc);
      end
      if (rst && sched_tx_req_val && prev_hs) begin
         gap_err <= gap_err + 1;
      end
   end

   function automatic logic [31:0] ent(input logic [2:0] f, input logic d, input logic r);
      return {27'd0, f, d, r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ent(input string tag, input int idx, input logic [31:0] exp);
      if (idx < iss_q.size()) chk(tag, iss_q[idx], exp);
      else chk(tag, 32'hFFFF_FFFF, exp);
   endtask

   task automatic cmd0(input logic v, input logic [2:0] f, input logic [1:0] op);
      src0_cmd_val = v;
      src0_cmd_flowid = f;
      src0_cmd_op = op;
   endtask

   task automatic wait_val(input string tag);
      int n = 0;
      while (!sched_tx_req_val && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(sched_tx_req_val), 32'd1);
   endtask

   // Holds reset two cycles, returns at the negedge where rst is released
   task automatic do_reset(input bit check_rst);
      @(negedge clk);
      rst = 1'b0;
      cmd0(1'b0, 3'd0, OP_NOP);
      src1_cmd_val = 1'b0;
      new_flow_val = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (check_rst) begin
         chk("rst_val", 32'(sched_tx_req_val), 32'd0);
         chk("rst_fid", 32'(sched_tx_req_flowid), 32'd0);
         chk("rst_bits", 32'({sched_tx_req_data, sched_tx_req_rtx}), 32'd0);
         chk("rst_rdy0", 32'(src0_cmd_rdy), 32'd0);
         chk("rst_rdy1", 32'(src1_cmd_rdy), 32'd0);
      end
      rst = 1'b1;
   endtask

   initial begin
      int b;
      int g0;
      bit ok;

      // T1: single SET_DATA to flow 5
      tx_sched_req_rdy = 1'b1;
      do_reset(1'b1);
      b = iss_q.size();
      @(negedge clk); cmd0(1'b1, 3'd5, OP_SET_DATA);
      @(negedge clk); cmd0(1'b0, 3'd0, OP_NOP);
      repeat (20) @(negedge clk);
      chk("t1_cnt", iss_q.size() - b, 32'd1);
      chk_ent("t1_req", b, ent(3'd5, 1'b1, 1'b0));

      // T2: simultaneous src0/src1 commands, src1 held until accepted
      do_reset(1'b0);
      b = iss_q.size();
      @(negedge clk);
      cmd0(1'b1, 3'd2, OP_SET_RTX);
      src1_cmd_val = 1'b1; src1_cmd_flowid = 3'd6; src1_cmd_op = OP_SET_DATA;
      #1;
      chk("t2_rdy1_blk", 32'(src1_cmd_rdy), 32'd0);
      chk("t2_rdy0", 32'(src0_cmd_rdy), 32'd1);
      @(negedge clk); cmd0(1'b0, 3'd0, OP_NOP);
      #1;
      chk("t2_rdy1_ok", 32'(src1_cmd_rdy), 32'd1);
      @(negedge clk); src1_cmd_val = 1'b0;
      repeat (24) @(negedge clk);
      chk("t2_cnt", iss_q.size() - b, 32'd2);
      chk_ent("t2_req0", b, ent(3'd2, 1'b0, 1'b1));
      chk_ent("t2_req1", b + 1, ent(3'd6, 1'b1, 1'b0));

      // T3: flow 3 stalled 10 cycles; new sets during the stall; pointer resumes at 4
      tx_sched_req_rdy = 1'b0;
      do_reset(1'b0);
      b = iss_q.size();
      @(negedge clk); cmd0(1'b1, 3'd3, OP_SET_DATA);
      @(negedge clk); cmd0(1'b0, 3'd0, OP_NOP);
      wait_val("t3_wait");
      ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         case (k)
            0: cmd0(1'b1, 3'd2, OP_SET_DATA);
            1: cmd0(1'b1, 3'd5, OP_SET_DATA);
            2: cmd0(1'b1, 3'd3, OP_SET_RTX);
            default: cmd0(1'b0, 3'd0, OP_NOP);
         endcase
         @(negedge clk);
         if (!(sched_tx_req_val && sched_tx_req_flowid == 3'd3 && sched_tx_req_data && !sched_tx_req_rtx))
            ok = 1'b0;
      end
      chk("t3_stable", 32'(ok), 32'd1);
`ifdef TX_FLOW_SCHED_PERF_CNT_EN
      chk("t3_stall_cnt", stall_cnt, 32'd10);
`endif
      tx_sched_req_rdy = 1'b1;
      repeat (30) @(negedge clk);
      chk("t3_cnt", iss_q.size() - b, 32'd4);
      chk_ent("t3_req0", b, ent(3'd3, 1'b1, 1'b0));
      chk_ent("t3_req1", b + 1, ent(3'd5, 1'b1, 1'b0));
      chk_ent("t3_req2", b + 2, ent(3'd2, 1'b1, 1'b0));
      chk_ent("t3_req3", b + 3, ent(3'd3, 1'b0, 1'b1));
`ifdef TX_FLOW_SCHED_PERF_CNT_EN
      chk("t3_issued_cnt", issued_cnt, 32'd4);
`endif

      // T4: SET_DATA to the offered flow in its handshake cycle survives the clear
      tx_sched_req_rdy = 1'b0;
      do_reset(1'b0);
      b = iss_q.size();
      @(negedge clk); cmd0(1'b1, 3'd3, OP_SET_DATA);
      @(negedge clk); cmd0(1'b0, 3'd0, OP_NOP);
      wait_val("t4_wait");
      tx_sched_req_rdy = 1'b1;
      cmd0(1'b1, 3'd3, OP_SET_DATA);
      @(negedge clk); cmd0(1'b0, 3'd0, OP_NOP);
      repeat (30) @(negedge clk);
      chk("t4_cnt", iss_q.size() - b, 32'd2);
      chk_ent("t4_req0", b, ent(3'd3, 1'b1, 1'b0));
      chk_ent("t4_req1", b + 1, ent(3'd3, 1'b1, 1'b0));
      if (iss_cyc.size() >= b + 2) chk("t4_regap", iss_cyc[b + 1] - iss_cyc[b], 32'd9);
      else chk("t4_regap", 32'hFFFF_FFFF, 32'd9);

      // T5: issue order 1,4,7 with idle gaps, then new_flow collisions on flow 4
      tx_sched_req_rdy = 1'b1;
      do_reset(1'b0);
      b = iss_q.size();
      g0 = gap_err;
      cmd0(1'b1, 3'd1, OP_SET_DATA);
      @(negedge clk); cmd0(1'b1, 3'd4, OP_SET_DATA);
      @(negedge clk); cmd0(1'b1, 3'd7, OP_SET_DATA);
      @(negedge clk); cmd0(1'b0, 3'd0, OP_NOP);
      repeat (20) @(negedge clk);
      chk("t5_cnt", iss_q.size() - b, 32'd3);
      chk_ent("t5_req0", b, ent(3'd1, 1'b1, 1'b0));
      chk_ent("t5_req1", b + 1, ent(3'd4, 1'b1, 1'b0));
      chk_ent("t5_req2", b + 2, ent(3'd7, 1'b1, 1'b0));
      chk("t5_gaps", gap_err - g0, 32'd0);
      @(negedge clk); cmd0(1'b1, 3'd4, OP_CLEAR);
      new_flow_val = 1'b1; new_flow_flowid = 3'd4;
      @(negedge clk); cmd0(1'b1, 3'd4, OP_SET_RTX);
      @(negedge clk); cmd0(1'b1, 3'd6, OP_SET_DATA);
      @(negedge clk); cmd0(1'b0, 3'd0, OP_NOP); new_flow_val = 1'b0;
      repeat (24) @(negedge clk);
      chk("t5_cnt_after", iss_q.size() - b, 32'd4);
      chk_ent("t5_req3", b + 3, ent(3'd6, 1'b1, 1'b0));

      // T6: reset during an offer drops it and clears all pending state
      tx_sched_req_rdy = 1'b0;
      do_reset(1'b0);
      @(negedge clk); cmd0(1'b1, 3'd2, OP_SET_DATA);
      @(negedge clk); cmd0(1'b0, 3'd0, OP_NOP);
      wait_val("t6_wait");
      chk("t6_fid", 32'(sched_tx_req_flowid), 32'd2);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_val", 32'(sched_tx_req_val), 32'd0);
      chk("t6_fid0", 32'(sched_tx_req_flowid), 32'd0);
      chk("t6_bits", 32'({sched_tx_req_data, sched_tx_req_rtx}), 32'd0);
      chk("t6_rdy0", 32'(src0_cmd_rdy), 32'd0);
      b = iss_q.size();
      tx_sched_req_rdy = 1'b1;
      @(negedge clk); rst = 1'b1;
      repeat (20) @(negedge clk);
      chk("t6_none", iss_q.size() - b, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
